// File: rtl/decryption_stream.sv
// decryption_stream: streaming decryptor, Plaintext = (Char_ciphertext + key) mod P_MOD, with a
// one-entry stage register feeding an output FIFO. Define DECRYPTION_PTXT_CHECK_EN to drop non-lowercase results.
module decryption_stream #(
  parameter int unsigned P_MOD      = 227,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  mode,
  input  logic        key_load,
  input  logic [7:0]  Public_key,
  input  logic        C_valid,
  input  logic [7:0]  Char_ciphertext,
  output logic        C_accept,
  output logic        P_valid,
  output logic [7:0]  Plaintext,
  input  logic        P_ready,
  output logic        err_invalid_ctxt,
  output logic        err_invalid_key,
  output logic        err_invalid_ptxt,
  output logic [15:0] char_count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [8:0]  P_MOD9  = 9'(P_MOD);
  localparam logic [CW:0] DEPTH_W = (CW+1)'(FIFO_DEPTH);

  typedef enum logic {NO_KEY, RUN} state_e;

  state_e          state_q, state_d;
  logic [7:0]      key_q, key_d;
  logic            stage_vld_q, stage_vld_d;
  logic [7:0]      stage_data_q, stage_data_d;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [7:0]      mem_d [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            err_ctxt_q, err_ctxt_d, err_key_q, err_key_d;
  logic [15:0]     char_count_q, char_count_d;

  logic            key_ok, ctxt_ok, ptxt_ok, take, fifo_wr, fifo_rd;
  logic [8:0]      sum;
  logic [7:0]      dec;
  logic [CW:0]     occupancy;

`ifdef DECRYPTION_PTXT_CHECK_EN
  logic err_ptxt_q, err_ptxt_d;

  assign ptxt_ok    = (stage_data_q >= 8'h61) && (stage_data_q <= 8'h7A);
  assign err_ptxt_d = stage_vld_q && !ptxt_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_ptxt_q <= 1'b0;
    else        err_ptxt_q <= err_ptxt_d;
  end

  assign err_invalid_ptxt = err_ptxt_q;
`else
  assign ptxt_ok          = 1'b1;
  assign err_invalid_ptxt = 1'b0;
`endif

  // Both operands are below P_MOD, so a single conditional subtract suffices.
  assign key_ok    = {1'b0, Public_key} < P_MOD9;
  assign ctxt_ok   = {1'b0, Char_ciphertext} < P_MOD9;
  assign sum       = {1'b0, Char_ciphertext} + {1'b0, key_q};
  assign dec       = 8'((sum >= P_MOD9) ? (sum - P_MOD9) : sum);

  // Occupancy counts the stage entry, so a valid stage always finds FIFO room.
  assign occupancy = {1'b0, count_q} + (CW+1)'(stage_vld_q);
  assign C_accept  = (state_q == RUN) && (mode == 2'b01) && (occupancy < DEPTH_W);
  assign take      = C_valid && C_accept;
  assign P_valid   = (count_q != '0);
  assign fifo_wr   = stage_vld_q && ptxt_ok;
  assign fifo_rd   = P_valid && P_ready;

  always_comb begin
    state_d      = state_q;
    key_d        = key_q;
    err_key_d    = 1'b0;
    err_ctxt_d   = take && !ctxt_ok;
    stage_vld_d  = take && ctxt_ok;
    stage_data_d = (take && ctxt_ok) ? dec : stage_data_q;
    mem_d        = mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q + CW'(fifo_wr) - CW'(fifo_rd);
    char_count_d = char_count_q;

    if (key_load) begin
      if (key_ok) begin
        key_d   = Public_key;
        state_d = RUN;
      end else begin
        err_key_d = 1'b1;
      end
    end

    if (fifo_wr) begin
      mem_d[wr_ptr_q] = stage_data_q;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end

    if (fifo_rd) begin
      rd_ptr_d     = rd_ptr_q + AW'(1);
      char_count_d = char_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= NO_KEY;
      key_q        <= '0;
      stage_vld_q  <= 1'b0;
      stage_data_q <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      err_ctxt_q   <= 1'b0;
      err_key_q    <= 1'b0;
      char_count_q <= '0;
    end else begin
      state_q      <= state_d;
      key_q        <= key_d;
      stage_vld_q  <= stage_vld_d;
      stage_data_q <= stage_data_d;
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      err_ctxt_q   <= err_ctxt_d;
      err_key_q    <= err_key_d;
      char_count_q <= char_count_d;
    end
  end

  assign Plaintext        = mem_q[rd_ptr_q];
  assign err_invalid_ctxt = err_ctxt_q;
  assign err_invalid_key  = err_key_q;
  assign char_count       = char_count_q;

endmodule

// File: tb/tb_decryption_stream.sv
// tb_decryption_stream: directed scenarios plus a randomized run checked against a
// queue-based model of (C + key) mod 227 delivery with stage/FIFO timing.
module tb_decryption_stream;

`ifdef DECRYPTION_PTXT_CHECK_EN
  localparam bit PTXT_CHK = 1'b1;
`else
  localparam bit PTXT_CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  mode;
  logic        key_load;
  logic [7:0]  Public_key;
  logic        C_valid;
  logic [7:0]  Char_ciphertext;
  logic        C_accept;
  logic        P_valid;
  logic [7:0]  Plaintext;
  logic        P_ready;
  logic        err_invalid_ctxt;
  logic        err_invalid_key;
  logic        err_invalid_ptxt;
  logic [15:0] char_count;

  int unsigned n_cmp = 0;
  int unsigned n_fail = 0;
  logic [15:0] exp_count;

  decryption_stream #(.P_MOD(227), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .key_load(key_load), .Public_key(Public_key),
    .C_valid(C_valid), .Char_ciphertext(Char_ciphertext), .C_accept(C_accept),
    .P_valid(P_valid), .Plaintext(Plaintext), .P_ready(P_ready),
    .err_invalid_ctxt(err_invalid_ctxt), .err_invalid_key(err_invalid_key),
    .err_invalid_ptxt(err_invalid_ptxt), .char_count(char_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; mode = 2'b00; key_load = 1'b0; Public_key = '0;
    C_valid = 1'b0; Char_ciphertext = '0; P_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    exp_count = '0;
  endtask

  task automatic load_key(input logic [7:0] k);
    key_load = 1'b1; Public_key = k;
    tick();
    key_load = 1'b0;
  endtask

  // Offers one character, waits (bounded) for acceptance, returns just after the transfer edge.
  task automatic send(input logic [7:0] c, output bit ok);
    C_valid = 1'b1; Char_ciphertext = c;
    #1;
    ok = 1'b0;
    for (int t = 0; t < 20 && !ok; t++) begin
      if (C_accept === 1'b1) ok = 1'b1;
      else tick();
    end
    if (ok) tick();
    C_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (C_accept !== 1'b0) begin n_fail++; $display("FAIL reset_c_accept: got %b want 0", C_accept); end
    n_cmp++; if (P_valid !== 1'b0) begin n_fail++; $display("FAIL reset_p_valid: got %b want 0", P_valid); end
    n_cmp++; if (Plaintext !== 8'h00) begin n_fail++; $display("FAIL reset_plaintext: got %h want 00", Plaintext); end
    n_cmp++; if ({err_invalid_ctxt, err_invalid_key, err_invalid_ptxt} !== 3'b000) begin
      n_fail++; $display("FAIL reset_err: got %b want 000", {err_invalid_ctxt, err_invalid_key, err_invalid_ptxt}); end
    n_cmp++; if (char_count !== 16'h0000) begin n_fail++; $display("FAIL reset_count: got %h want 0000", char_count); end
    mode = 2'b01;
    tick();
    n_cmp++; if (C_accept !== 1'b0) begin n_fail++; $display("FAIL reset_no_key_accept: got %b want 0", C_accept); end
  endtask

  task automatic test_invalid_key();
    mode = 2'b01;
    load_key(8'hE5);
    n_cmp++; if (err_invalid_key !== 1'b1) begin n_fail++; $display("FAIL bad_key_pulse: got %b want 1", err_invalid_key); end
    n_cmp++; if (C_accept !== 1'b0) begin n_fail++; $display("FAIL bad_key_accept: got %b want 0", C_accept); end
    tick();
    n_cmp++; if (err_invalid_key !== 1'b0) begin n_fail++; $display("FAIL bad_key_pulse_end: got %b want 0", err_invalid_key); end
    n_cmp++; if (C_accept !== 1'b0) begin n_fail++; $display("FAIL bad_key_accept2: got %b want 0", C_accept); end
  endtask

  task automatic test_basic();
    bit ok;
    P_ready = 1'b1; mode = 2'b01;
    load_key(8'h0A);
    n_cmp++; if (C_accept !== 1'b1) begin n_fail++; $display("FAIL basic_accept: got %b want 1", C_accept); end
    send(8'h57, ok);
    n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL basic_timeout: accepted %b want 1", ok); end
    n_cmp++; if (P_valid !== 1'b0) begin n_fail++; $display("FAIL basic_latency1: P_valid %b want 0", P_valid); end
    tick();
    n_cmp++; if (P_valid !== 1'b1) begin n_fail++; $display("FAIL basic_latency2: P_valid %b want 1", P_valid); end
    n_cmp++; if (Plaintext !== 8'h61) begin n_fail++; $display("FAIL basic_data: got %h want 61", Plaintext); end
    tick();
    exp_count++;
    n_cmp++; if (char_count !== exp_count) begin n_fail++; $display("FAIL basic_count: got %0d want %0d", char_count, exp_count); end
    n_cmp++; if (P_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drained: P_valid %b want 0", P_valid); end
  endtask

  task automatic test_wrap();
    bit ok;
    P_ready = 1'b1; mode = 2'b01;
    load_key(8'hC8);
    send(8'h7D, ok);
    tick();
    n_cmp++; if (ok !== 1'b1 || P_valid !== 1'b1 || Plaintext !== 8'h62) begin
      n_fail++; $display("FAIL wrap_325: ok %b P_valid %b data %h want 1 1 62", ok, P_valid, Plaintext); end
    tick(); exp_count++;
    load_key(8'h61);
    send(8'h00, ok);
    tick();
    n_cmp++; if (ok !== 1'b1 || P_valid !== 1'b1 || Plaintext !== 8'h61) begin
      n_fail++; $display("FAIL wrap_zero: ok %b P_valid %b data %h want 1 1 61", ok, P_valid, Plaintext); end
    tick(); exp_count++;
    n_cmp++; if (char_count !== exp_count) begin n_fail++; $display("FAIL wrap_count: got %0d want %0d", char_count, exp_count); end
  endtask

  task automatic test_invalid_ctxt();
    bit ok;
    P_ready = 1'b1; mode = 2'b01;
    send(8'hE3, ok);
    n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL bad_ctxt_xfer: accepted %b want 1", ok); end
    n_cmp++; if (err_invalid_ctxt !== 1'b1) begin n_fail++; $display("FAIL bad_ctxt_pulse: got %b want 1", err_invalid_ctxt); end
    tick();
    n_cmp++; if (err_invalid_ctxt !== 1'b0) begin n_fail++; $display("FAIL bad_ctxt_pulse_end: got %b want 0", err_invalid_ctxt); end
    n_cmp++; if (P_valid !== 1'b0) begin n_fail++; $display("FAIL bad_ctxt_pvalid: got %b want 0", P_valid); end
    tick();
    n_cmp++; if (char_count !== exp_count) begin n_fail++; $display("FAIL bad_ctxt_count: got %0d want %0d", char_count, exp_count); end
  endtask

  task automatic test_backpressure();
    int unsigned idx;
    int unsigned k;
    bit acc_now;
    mode = 2'b01; P_ready = 1'b0;
    load_key(8'h05);
    idx = 0;
    for (int t = 0; t < 8; t++) begin
      C_valid = (idx < 6); Char_ciphertext = 8'(8'h5C + idx);
      #1;
      acc_now = C_valid && C_accept;
      if (P_valid === 1'b1) begin
        n_cmp++; if (Plaintext !== 8'h61) begin n_fail++; $display("FAIL bp_hold: got %h want 61", Plaintext); end
      end
      tick();
      if (acc_now) idx++;
    end
    n_cmp++; if (idx !== 4) begin n_fail++; $display("FAIL bp_accepted: got %0d want 4", idx); end
    C_valid = 1'b1; Char_ciphertext = 8'h60;
    #1;
    n_cmp++; if (C_accept !== 1'b0) begin n_fail++; $display("FAIL bp_full_accept: got %b want 0", C_accept); end
    C_valid = 1'b0;
    P_ready = 1'b1;
    k = 0;
    for (int t = 0; t < 20 && k < 4; t++) begin
      if (P_valid === 1'b1) begin
        n_cmp++; if (Plaintext !== 8'(8'h61 + k)) begin n_fail++; $display("FAIL bp_order: got %h want %h", Plaintext, 8'(8'h61 + k)); end
        k++; exp_count++;
      end
      tick();
    end
    n_cmp++; if (k !== 4) begin n_fail++; $display("FAIL bp_delivered: got %0d want 4", k); end
    n_cmp++; if (char_count !== exp_count) begin n_fail++; $display("FAIL bp_count: got %0d want %0d", char_count, exp_count); end
  endtask

  task automatic test_macro();
    bit ok;
    P_ready = 1'b1; mode = 2'b01;
    load_key(8'h10);
    send(8'h00, ok);
    n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL macro_xfer: accepted %b want 1", ok); end
    tick();
    if (PTXT_CHK) begin
      n_cmp++; if (err_invalid_ptxt !== 1'b1 || P_valid !== 1'b0) begin
        n_fail++; $display("FAIL macro_drop: err %b P_valid %b want 1 0", err_invalid_ptxt, P_valid); end
      tick();
      n_cmp++; if (err_invalid_ptxt !== 1'b0) begin n_fail++; $display("FAIL macro_pulse_end: got %b want 0", err_invalid_ptxt); end
    end else begin
      n_cmp++; if (P_valid !== 1'b1 || Plaintext !== 8'h10 || err_invalid_ptxt !== 1'b0) begin
        n_fail++; $display("FAIL macro_pass: P_valid %b data %h err %b want 1 10 0", P_valid, Plaintext, err_invalid_ptxt); end
      tick();
      exp_count++;
    end
    n_cmp++; if (char_count !== exp_count) begin n_fail++; $display("FAIL macro_count: got %0d want %0d", char_count, exp_count); end
  endtask

  typedef struct {
    logic [7:0]  d;
    int unsigned tag;
    bit          drop;
  } item_t;

  task automatic test_random();
    item_t       q[$];
    item_t       it;
    bit          have_key;
    logic [7:0]  mkey;
    int unsigned ecnt;
    bit          e_c, e_k, e_p, exp_acc, exp_pv;
    logic [15:0] mcnt;
    do_reset();
    have_key = 0; mkey = '0; ecnt = 0; e_c = 0; e_k = 0; e_p = 0; mcnt = '0;
    for (int cyc = 0; cyc < 500; cyc++) begin
      mode     = ($urandom_range(0, 9) < 8) ? 2'b01 : 2'($urandom_range(0, 3));
      P_ready  = ($urandom_range(0, 9) < 6);
      key_load = ($urandom_range(0, 99) < 6) || (cyc == 3);
      Public_key = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(227, 255)) : 8'($urandom_range(0, 226));
      C_valid  = !key_load && ($urandom_range(0, 9) < 7);
      Char_ciphertext = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(227, 255)) : 8'($urandom_range(0, 226));
      #1;
      exp_acc = have_key && (mode == 2'b01) && (q.size() < 4);
      exp_pv  = (q.size() > 0) && (q[0].tag < ecnt);
      n_cmp++; if (C_accept !== exp_acc) begin n_fail++; $display("FAIL rnd_accept cyc %0d: got %b want %b", cyc, C_accept, exp_acc); end
      n_cmp++; if (P_valid !== exp_pv) begin n_fail++; $display("FAIL rnd_pvalid cyc %0d: got %b want %b", cyc, P_valid, exp_pv); end
      if (exp_pv) begin
        n_cmp++; if (Plaintext !== q[0].d) begin n_fail++; $display("FAIL rnd_data cyc %0d: got %h want %h", cyc, Plaintext, q[0].d); end
      end
      n_cmp++; if (char_count !== mcnt) begin n_fail++; $display("FAIL rnd_count cyc %0d: got %0d want %0d", cyc, char_count, mcnt); end
      n_cmp++; if ({err_invalid_ctxt, err_invalid_key, err_invalid_ptxt} !== {e_c, e_k, e_p}) begin
        n_fail++; $display("FAIL rnd_err cyc %0d: got %b want %b", cyc,
                           {err_invalid_ctxt, err_invalid_key, err_invalid_ptxt}, {e_c, e_k, e_p}); end
      e_c = 0; e_k = 0; e_p = 0;
      if (exp_pv && P_ready) begin
        void'(q.pop_front());
        mcnt++;
      end
      if (C_valid && exp_acc) begin
        if (Char_ciphertext < 8'd227) begin
          it.d    = 8'((int'(Char_ciphertext) + int'(mkey)) % 227);
          it.tag  = ecnt + 1;
          it.drop = PTXT_CHK && !(it.d >= 8'h61 && it.d <= 8'h7A);
          q.push_back(it);
        end else begin
          e_c = 1;
        end
      end
      if (key_load) begin
        if (Public_key < 8'd227) begin mkey = Public_key; have_key = 1; end
        else e_k = 1;
      end
      ecnt++;
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (q[i].drop && q[i].tag < ecnt) begin q.delete(i); e_p = 1; end
      end
      tick();
    end
    key_load = 1'b0; C_valid = 1'b0;
    exp_count = mcnt;
  endtask

  task automatic test_reset_midstream();
    bit ok;
    do_reset();
    mode = 2'b01; P_ready = 1'b1;
    load_key(8'h05);
    send(8'h5C, ok);
    repeat (2) tick();
    exp_count++;
    P_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(8'(8'h5D + i), ok);
    tick();
    n_cmp++; if (P_valid !== 1'b1 || char_count !== exp_count) begin
      n_fail++; $display("FAIL mid_buffered: P_valid %b count %0d want 1 %0d", P_valid, char_count, exp_count); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (P_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_pvalid: got %b want 0", P_valid); end
    n_cmp++; if (char_count !== 16'h0000) begin n_fail++; $display("FAIL mid_rst_count: got %0d want 0", char_count); end
    n_cmp++; if (C_accept !== 1'b0) begin n_fail++; $display("FAIL mid_rst_accept: got %b want 0", C_accept); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    C_valid = 1'b1; Char_ciphertext = 8'h5C;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (C_accept !== 1'b0 || P_valid !== 1'b0) begin
        n_fail++; $display("FAIL mid_no_key: C_accept %b P_valid %b want 0 0", C_accept, P_valid); end
    end
    C_valid = 1'b0;
    load_key(8'h20);
    n_cmp++; if (C_accept !== 1'b1) begin n_fail++; $display("FAIL mid_rekey_accept: got %b want 1", C_accept); end
  endtask

  initial begin
    exp_count = '0;
    test_reset();
    test_invalid_key();
    test_basic();
    test_wrap();
    test_invalid_ctxt();
    test_backpressure();
    test_macro();
    test_random();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/decryption_stream.md
# decryption_stream

Streaming decryptor, inverse of the team's modular-subtraction encryptor: recovers each plaintext character as P = (C + Pk) mod 227 from a ciphertext character stream and a loaded public key. It sits between the ciphertext source and the plaintext consumer. Input and output use valid/ready handshakes with a small output FIFO for backpressure. It flags out-of-range ciphertext and keys, and counts delivered characters.

## Interface
- P_MOD, 227, modulus; ciphertext and key must be strictly below it
- FIFO_DEPTH, 4, output FIFO entries (power of two, ≥2)
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- mode  in  2  operating mode; 2'b01 = decrypt, any other value = idle
- key_load  in  1  one-cycle strobe; samples Public_key
- Public_key  in  8  key value, valid when key_load=1
- C_valid  in  1  ciphertext character offered
- Char_ciphertext  in  8  ciphertext character
- C_accept  out  1  block accepts Char_ciphertext this cycle
- P_valid  out  1  FIFO head valid
- Plaintext  out  8  FIFO head character
- P_ready  in  1  consumer takes Plaintext this cycle
- err_invalid_ctxt  out  1  one-cycle pulse: dropped ciphertext ≥ P_MOD
- err_invalid_key  out  1  one-cycle pulse: rejected key ≥ P_MOD
- err_invalid_ptxt  out  1  one-cycle pulse: dropped non-lowercase result (macro only, else tied 0)
- char_count  out  16  characters delivered since reset

## Operation
- FSM states:
  - NO_KEY (reset state)
  - RUN
- NO_KEY:
  - C_accept=0.
  - key_load with Public_key<P_MOD: store key, go to RUN.
  - key_load with Public_key≥P_MOD: pulse err_invalid_key, stay in NO_KEY.
- RUN:
  - key_load with valid key: replaces the key from the next accepted character on. Characters already accepted keep the old key.
  - key_load with invalid key: pulse err_invalid_key, keep the old key, stay in RUN.
- C_accept = (state==RUN) && (mode==2'b01) && (occupancy < FIFO_DEPTH).
  - occupancy = FIFO count + stage register valid.
- A transfer occurs when C_valid && C_accept.
- Stage register (one character):
  - Char_ciphertext ≥ P_MOD: character dropped, err_invalid_ctxt pulses the next cycle, stage not loaded.
  - Otherwise: sum = C + key in 9 bits. If sum ≥ P_MOD, subtract P_MOD. Result is always < P_MOD and needs no second correction.
- Stage register → FIFO write on the following edge.
- FIFO read when P_valid && P_ready. Simultaneous read and write at full or empty is legal and keeps occupancy consistent.
- Mode leaving 2'b01: no new accepts; stage and FIFO continue to drain.
- char_count increments on each P_valid && P_ready and wraps 16'hFFFF → 0.

## Timing
- Reset values:
  - C_accept=0, P_valid=0, Plaintext=8'h00
  - all err_* = 0, char_count=0
  - state=NO_KEY, key=0, FIFO empty
- Reset mid-operation discards the stage register, the FIFO contents and the key immediately (asynchronous).
- Key accepted at edge K: C_accept may rise in the cycle after edge K.
- Latency:
  - Character accepted at edge N is in the stage register after N.
  - It is in the FIFO after N+1.
  - With the FIFO empty, P_valid=1 and Plaintext is valid after edge N+1, i.e. 2 cycles.
- Throughput: one character per cycle when P_ready=1.
- Error pulses are registered and high for exactly the one cycle after the offending edge.
- Plaintext is a registered FIFO head. It holds stable while P_valid && !P_ready.

## Configuration
- DECRYPTION_PTXT_CHECK_EN defined:
  - A result outside 8'h61..8'h7A is not written to the FIFO.
  - err_invalid_ptxt pulses in the cycle after the stage→FIFO edge.
  - char_count does not count dropped results.
- Not defined:
  - Every result in range is delivered.
  - err_invalid_ptxt is tied to 0.

## Test plan
- Basic decrypt:
  - Stimulus: key_load with Public_key=8'h0A; mode=2'b01; C=8'h57; P_ready=1.
  - Required: Plaintext=8'h61, P_valid 2 cycles after accept; char_count=1.
- Modular wrap:
  - Stimulus: key=8'hC8 (200); C=8'h7D (125).
  - Required: Plaintext=8'h62 (325−227).
  - Also: C=8'h00 with key=8'h61 gives 8'h61.
- Invalid inputs:
  - Key 8'hE5 in NO_KEY: err_invalid_key one-cycle pulse; C_accept stays 0.
  - C=8'hE3 in RUN: err_invalid_ctxt pulse; no P_valid; char_count unchanged.
- Backpressure:
  - Stimulus: P_ready=0; offer 6 valid characters with FIFO_DEPTH=4.
  - Required: 4 accepted, then C_accept=0 and Plaintext held stable.
  - Then release P_ready: all 4 delivered in order.
- Reset mid-stream:
  - Stimulus: assert rst_n=0 with 3 characters buffered.
  - Required: immediately P_valid=0, char_count=0, C_accept=0.
  - After release: state NO_KEY until a new key_load.
- Macro check:
  - Stimulus: key=8'h10, C=8'h00 (result 8'h10).
  - With DECRYPTION_PTXT_CHECK_EN: dropped, err_invalid_ptxt pulse.
  - Without: Plaintext=8'h10 delivered.
